// File: rtl/tree_pkg.sv
// rtl/tree_pkg.sv - shared types and constants for the tree uplink arbiter
package tree_pkg;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_SAT = 8'd255;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant searching upward from ptr+1
module rr_arbiter #(
  parameter int N     = 10,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_grant
);

  // First requester at or after ptr+1, wrapping modulo N
  always_comb begin
    int  cand;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      for (int i = 0; i < N; i++) begin
        if (!found && (cand == i) && req[i]) begin
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
          found     = 1'b1;
        end
      end
    end
    any_grant = found;
  end

endmodule

// File: rtl/tree_uplink_arbiter.sv
// rtl/tree_uplink_arbiter.sv - merges child uplinks into one registered parent stream
module tree_uplink_arbiter
  import tree_pkg::*;
#(
  parameter int NUM_CHILD = 10,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CHILD-1:0]        ch_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] ch_data,
  output logic [NUM_CHILD-1:0]        ch_ready,
  output logic                        up_valid,
  input  logic                        up_ready,
  output logic [DATA_W-1:0]           up_data,
  output logic [IDX_W-1:0]            up_idx,
  input  logic [IDX_W-1:0]            cnt_sel,
  output logic [CNT_W-1:0]            cnt_rd
);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  up_data_q, up_data_d;
  logic [IDX_W-1:0]   up_idx_q, up_idx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  cnt_t               cnt_q [NUM_CHILD];
  cnt_t               cnt_d [NUM_CHILD];
  cnt_t               cnt_rd_q, cnt_rd_d;

  logic [NUM_CHILD-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;
  logic                 any_grant;
  logic                 accept_en;
  logic                 hs;
  logic [DATA_W-1:0]    data_mux;

  rr_arbiter #(
    .N     (NUM_CHILD),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (ch_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A new message may be taken when the output register is free or draining this cycle
  assign accept_en = rst_n && ((state_q == ST_EMPTY) || up_ready);
  assign hs        = any_grant && accept_en;

  // State register plus all datapath flops; reset drops any held message
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      up_data_q <= '0;
      up_idx_q  <= '0;
      rr_ptr_q  <= IDX_W'(NUM_CHILD - 1);
      cnt_rd_q  <= '0;
      for (int i = 0; i < NUM_CHILD; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      up_data_q <= up_data_d;
      up_idx_q  <= up_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_rd_q  <= cnt_rd_d;
      for (int i = 0; i < NUM_CHILD; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Next state: a load always leaves us FULL, a bare drain empties the register
  always_comb begin
    state_d = state_q;
    if (hs) begin
      state_d = ST_FULL;
    end else if ((state_q == ST_FULL) && up_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // FSM outputs: parent valid and the gated one-hot child accept
  always_comb begin
    up_valid = (state_q == ST_FULL);
    ch_ready = accept_en ? grant : '0;
  end

  // Payload selection, pointer advance, saturating counters and readback mux
  always_comb begin
    data_mux = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (grant[i]) data_mux = ch_data[i*DATA_W +: DATA_W];
    end

    up_data_d = up_data_q;
    up_idx_d  = up_idx_q;
    rr_ptr_d  = rr_ptr_q;
    if (hs) begin
      up_data_d = data_mux;
      up_idx_d  = grant_idx;
      rr_ptr_d  = grant_idx;
    end

    for (int i = 0; i < NUM_CHILD; i++) begin
      cnt_d[i] = cnt_q[i];
      if (hs && grant[i] && (cnt_q[i] != CNT_SAT)) cnt_d[i] = cnt_q[i] + cnt_t'(1);
    end

    cnt_rd_d = '0;
    for (int i = 0; i < NUM_CHILD; i++) begin
      if (cnt_sel == IDX_W'(i)) cnt_rd_d = cnt_q[i];
    end
  end

  assign up_data = up_data_q;
  assign up_idx  = up_idx_q;
  assign cnt_rd  = cnt_rd_q;

endmodule

// File: tb/tb_tree_uplink_arbiter.sv
// tb/tb_tree_uplink_arbiter.sv - directed self-checking bench for tree_uplink_arbiter
module tb_tree_uplink_arbiter;

  localparam int NC = 10;
  localparam int DW = 16;
  localparam int IW = 4;

  logic             clk;
  logic             rst_n;
  logic [NC-1:0]    ch_valid;
  logic [NC*DW-1:0] ch_data;
  logic [NC-1:0]    ch_ready;
  logic             up_valid;
  logic             up_ready;
  logic [DW-1:0]    up_data;
  logic [IW-1:0]    up_idx;
  logic [IW-1:0]    cnt_sel;
  logic [7:0]       cnt_rd;

  int checks = 0;
  int errors = 0;

  tree_uplink_arbiter #(
    .NUM_CHILD (NC),
    .DATA_W    (DW),
    .IDX_W     (IW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_valid (ch_valid),
    .ch_data  (ch_data),
    .ch_ready (ch_ready),
    .up_valid (up_valid),
    .up_ready (up_ready),
    .up_data  (up_data),
    .up_idx   (up_idx),
    .cnt_sel  (cnt_sel),
    .cnt_rd   (cnt_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NC-1:0] exp_rdy;

    rst_n    = 1'b0;
    ch_valid = '1;
    up_ready = 1'b0;
    cnt_sel  = '0;
    for (int i = 0; i < NC; i++) ch_data[i*DW +: DW] = 16'(16'h1000 + i);

    // Reset with every child requesting
    #2;
    check("rst_ch_ready", 32'(ch_ready), 32'h0);
    check("rst_up_valid", 32'(up_valid), 32'h0);
    tick();
    tick();
    check("rst_ch_ready_hold", 32'(ch_ready), 32'h0);
    check("rst_up_data", 32'(up_data), 32'h0);
    check("rst_up_idx", 32'(up_idx), 32'h0);
    check("rst_cnt_rd", 32'(cnt_rd), 32'h0);

    // Release: first grant goes to child 0
    rst_n = 1'b1;
    #1;
    check("first_grant", 32'(ch_ready), 32'h001);

    // Fairness: 20 back-to-back messages, 0..9 twice
    up_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("fair_valid", 32'(up_valid), 32'h1);
      check("fair_idx", 32'(up_idx), 32'(k % 10));
      check("fair_data", 32'(up_data), 32'(16'h1000 + (k % 10)));
      exp_rdy = '0;
      exp_rdy[(k + 1) % 10] = 1'b1;
      check("fair_ready", 32'(ch_ready), 32'(exp_rdy));
    end
    ch_valid = '0;
    #1;
    check("idle_ready_zero", 32'(ch_ready), 32'h0);
    tick();
    check("drain_empty", 32'(up_valid), 32'h0);
    cnt_sel = 4'd0;
    tick();
    check("cnt_child0", 32'(cnt_rd), 32'd2);

    // Backpressure: child 3 holds 0xBEEF for 5 stalled cycles
    up_ready = 1'b0;
    ch_data[3*DW +: DW] = 16'hBEEF;
    ch_valid = 10'b00_0000_1000;
    #1;
    check("bp_accept", 32'(ch_ready), 32'h008);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(up_valid), 32'h1);
      check("bp_data", 32'(up_data), 32'hBEEF);
      check("bp_idx", 32'(up_idx), 32'd3);
      check("bp_ready", 32'(ch_ready), 32'h0);
      tick();
    end

    // Simultaneous drain and load from child 5
    ch_data[5*DW +: DW] = 16'h5555;
    ch_valid = 10'b00_0010_0000;
    up_ready = 1'b1;
    #1;
    check("dl_ready", 32'(ch_ready), 32'h020);
    tick();
    check("dl_valid", 32'(up_valid), 32'h1);
    check("dl_idx", 32'(up_idx), 32'd5);
    check("dl_data", 32'(up_data), 32'h5555);
    ch_valid = '0;
    tick();
    check("dl_drained", 32'(up_valid), 32'h0);

    // Wrap-around search: ptr=5, children 2 and 4 -> 2
    up_ready = 1'b0;
    ch_valid = 10'b00_0001_0100;
    #1;
    check("rr_wrap", 32'(ch_ready), 32'h004);
    ch_valid = '0;
    cnt_sel = 4'd3;
    tick();
    check("cnt_child3", 32'(cnt_rd), 32'd3);

    // Saturation: 300 more messages from child 9
    ch_valid = 10'b10_0000_0000;
    up_ready = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    check("sat_idx", 32'(up_idx), 32'd9);
    ch_valid = '0;
    tick();
    cnt_sel = 4'd9;
    tick();
    check("sat_cnt9", 32'(cnt_rd), 32'd255);
    cnt_sel = 4'd12;
    tick();
    check("sel_out_of_range", 32'(cnt_rd), 32'h0);

    // Reset while FULL
    up_ready = 1'b0;
    ch_valid = 10'b00_0000_0010;
    tick();
    check("mid_full", 32'(up_valid), 32'h1);
    check("mid_idx", 32'(up_idx), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(up_valid), 32'h0);
    check("mid_rst_ready", 32'(ch_ready), 32'h0);
    check("mid_rst_data", 32'(up_data), 32'h0);
    tick();
    rst_n    = 1'b1;
    ch_valid = '0;
    cnt_sel  = 4'd9;
    tick();
    check("no_replay", 32'(up_valid), 32'h0);
    check("post_rst_cnt9", 32'(cnt_rd), 32'h0);
    ch_valid = '1;
    #1;
    check("post_rst_grant", 32'(ch_ready), 32'h001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
